// File: rtl/rv_ex_pkg.sv
// Shared encodings for the RV32 execute stage: forwarding selects,
// ALU operations, RV32M funct3 values and the mul/div FSM states.
package rv_ex_pkg;

  // Forwarding selects. 2'b11 falls back to the register-file value.
  localparam logic [1:0] FWD_RD = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // RV32M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Multi-cycle RV32M unit: latches operands on start, times the multiplier,
// runs a restoring 1-bit/cycle divider on magnitudes and fixes signs at the end.
module md_unit
  import rv_ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int MUL_CNT = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
  localparam int CNT_MAX = (XLEN - 1 > MUL_CNT) ? XLEN - 1 : MUL_CNT;
  localparam int CW      = $clog2(CNT_MAX + 2);

  md_state_t       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            neg_quo_q, neg_rem_q;

  // Operand classification for the instruction presented at start
  logic            signed_div, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag;

  assign signed_div = ~op[0];
  assign a_neg      = signed_div & a[XLEN-1];
  assign b_neg      = signed_div & b[XLEN-1];
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  assign div_zero   = (b == '0);
  assign div_ovf    = signed_div & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign special    = md_is_div(op) & (div_zero | div_ovf);

  // One restoring-division step on the latched magnitudes
  logic [XLEN:0] shifted, diff;
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // Stall covers the accepting cycle and every BUSY cycle; flush or reset drop it at once
  assign busy = rst_n & ~flush & (((state_q == MD_IDLE) & start) | (state_q == MD_BUSY));
  assign done = (state_q == MD_DONE);

  // FSM, counter, operand latches and divider datapath
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values; = here would chain updates within one edge.
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush) begin
      state_q <= MD_IDLE;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start) begin
            op_q      <= op;
            a_q       <= a;
            b_q       <= b;
            dvs_q     <= b_mag;
            quo_q     <= a_mag;
            rem_q     <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (special) begin
              // Preload the final answers; sign fix-up is disabled
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              quo_q     <= div_zero ? '1 : a;
              rem_q     <= div_zero ? a  : '0;
              state_q   <= MD_DONE;
            end else if (!md_is_div(op) && (MUL_CYCLES == 1)) begin
              state_q <= MD_DONE;
            end else begin
              state_q <= MD_BUSY;
              cnt_q   <= md_is_div(op) ? CW'(XLEN - 1) : CW'(MUL_CNT);
            end
          end
        end
        MD_BUSY: begin
          if (md_is_div(op_q)) begin
            rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= MD_DONE;
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  // Product with per-op operand signedness, from the latched operands
  logic [XLEN:0]         a_ext, b_ext;
  logic signed [2*XLEN-1:0] prod;

  assign a_ext = {(op_q != MD_MULHU) & a_q[XLEN-1], a_q};
  assign b_ext = {((op_q == MD_MUL) | (op_q == MD_MULH)) & b_q[XLEN-1], b_q};
  assign prod  = (2*XLEN)'($signed(a_ext)) * (2*XLEN)'($signed(b_ext));

  // Final result selection with sign correction of quotient/remainder
  always_comb begin
    // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
    result = '0;
    unique case (op_q)
      MD_MUL:                       result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = neg_quo_q ? -quo_q : quo_q;
      MD_REM, MD_REMU:              result = neg_rem_q ? -rem_q : rem_q;
      default:                      result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage_md.sv
// RV32 execute stage: operand forwarding, ALU, branch/jump target and
// decision, the multi-cycle RV32M unit, and the EX/MEM pipeline register.
module ex_stage_md
  import rv_ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_E,
  input  logic              regWrite_E,
  input  logic              memWrite_E,
  input  logic              memRead_E,
  input  logic [2:0]        resultScr_E,
  input  logic [3:0]        alu_ctrl_E,
  input  logic              alu_srcB_E,
  input  logic              muxjalr,
  input  logic              jump_E,
  input  logic              branch_E,
  input  logic [2:0]        funct3,
  input  logic              md_en_E,
  input  logic [XLEN-1:0]   pc_E,
  input  logic [XLEN-1:0]   pc4_E,
  input  logic [XLEN-1:0]   imm_extended_E,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [REG_AW-1:0] rd_E,
  input  logic [2:0]        mode_E,
  output logic              stall_E,
  output logic              PCSrc_E,
  output logic [XLEN-1:0]   PC_target_E,
  output logic              regWrite_M,
  output logic              memWrite_M,
  output logic              memRead_M,
  output logic [2:0]        resultScr_M,
  output logic [XLEN-1:0]   ALURuslt_M,
  output logic [XLEN-1:0]   imm_extended_M,
  output logic [XLEN-1:0]   write_Data_M,
  output logic [XLEN-1:0]   PC_target_mux_M,
  output logic [REG_AW-1:0] rd_M,
  output logic [XLEN-1:0]   pc4_M,
  output logic [2:0]        mode_M
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_result, md_result;
  logic [SHW-1:0]  shamt;
  logic            zero, md_busy, md_done;

  assign shamt = src_b[SHW-1:0];

  // Forwarding muxes, srcB select and ALU
  always_comb begin
    unique case (ForwardAE)
      FWD_W:   fwd_a = ResultW;
      FWD_M:   fwd_a = ALURuslt_M;
      default: fwd_a = RD1_E;
    endcase
    unique case (ForwardBE)
      FWD_W:   fwd_b = ResultW;
      FWD_M:   fwd_b = ALURuslt_M;
      default: fwd_b = RD2_E;
    endcase
    src_b = alu_srcB_E ? imm_extended_E : fwd_b;
    unique case (alu_ctrl_E)
      ALU_ADD:  alu_result = fwd_a + src_b;
      ALU_SUB:  alu_result = fwd_a - src_b;
      ALU_AND:  alu_result = fwd_a & src_b;
      ALU_OR:   alu_result = fwd_a | src_b;
      ALU_XOR:  alu_result = fwd_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, fwd_a < src_b};
      ALU_SLL:  alu_result = fwd_a << shamt;
      ALU_SRL:  alu_result = fwd_a >> shamt;
      ALU_SRA:  alu_result = XLEN'($signed(fwd_a) >>> shamt);
      default:  alu_result = '0;
    endcase
  end

  assign zero        = (alu_result == '0);
  assign PCSrc_E     = (zero & branch_E) | jump_E;
  assign PC_target_E = (muxjalr ? pc_E : fwd_a) + imm_extended_E;
  assign stall_E     = md_busy;

  md_unit #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_en_E),
    .flush  (flush_E),
    .op     (funct3),
    .a      (fwd_a),
    .b      (fwd_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // EX/MEM register; control bits take a bubble on stall or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWrite_M      <= 1'b0;
      memWrite_M      <= 1'b0;
      memRead_M       <= 1'b0;
      resultScr_M     <= '0;
      ALURuslt_M      <= '0;
      imm_extended_M  <= '0;
      write_Data_M    <= '0;
      PC_target_mux_M <= '0;
      rd_M            <= '0;
      pc4_M           <= '0;
      mode_M          <= '0;
    end else begin
      if (flush_E || stall_E) begin
        regWrite_M <= 1'b0;
        memWrite_M <= 1'b0;
        memRead_M  <= 1'b0;
      end else begin
        regWrite_M <= regWrite_E;
        memWrite_M <= memWrite_E;
        memRead_M  <= memRead_E;
      end
      resultScr_M     <= resultScr_E;
      ALURuslt_M      <= md_done ? md_result : alu_result;
      imm_extended_M  <= imm_extended_E;
      write_Data_M    <= fwd_b;
      PC_target_mux_M <= PC_target_E;
      rd_M            <= rd_E;
      pc4_M           <= pc4_E;
      mode_M          <= mode_E;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: forwarding, ALU, branch target,
// RV32M timing and results, special divide cases, flush and reset.
module tb_ex_stage_md;
  import rv_ex_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush_E, regWrite_E, memWrite_E, memRead_E;
  logic [2:0]        resultScr_E;
  logic [3:0]        alu_ctrl_E;
  logic              alu_srcB_E, muxjalr, jump_E, branch_E;
  logic [2:0]        funct3;
  logic              md_en_E;
  logic [XLEN-1:0]   pc_E, pc4_E, imm_extended_E, RD1_E, RD2_E, ResultW;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [REG_AW-1:0] rd_E;
  logic [2:0]        mode_E;
  logic              stall_E, PCSrc_E;
  logic [XLEN-1:0]   PC_target_E;
  logic              regWrite_M, memWrite_M, memRead_M;
  logic [2:0]        resultScr_M;
  logic [XLEN-1:0]   ALURuslt_M, imm_extended_M, write_Data_M, PC_target_mux_M, pc4_M;
  logic [REG_AW-1:0] rd_M;
  logic [2:0]        mode_M;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_stage_md #(.XLEN(XLEN), .MUL_CYCLES(2), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_E(flush_E),
    .regWrite_E(regWrite_E), .memWrite_E(memWrite_E), .memRead_E(memRead_E),
    .resultScr_E(resultScr_E), .alu_ctrl_E(alu_ctrl_E), .alu_srcB_E(alu_srcB_E),
    .muxjalr(muxjalr), .jump_E(jump_E), .branch_E(branch_E), .funct3(funct3),
    .md_en_E(md_en_E), .pc_E(pc_E), .pc4_E(pc4_E), .imm_extended_E(imm_extended_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .ResultW(ResultW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .rd_E(rd_E), .mode_E(mode_E),
    .stall_E(stall_E), .PCSrc_E(PCSrc_E), .PC_target_E(PC_target_E),
    .regWrite_M(regWrite_M), .memWrite_M(memWrite_M), .memRead_M(memRead_M),
    .resultScr_M(resultScr_M), .ALURuslt_M(ALURuslt_M), .imm_extended_M(imm_extended_M),
    .write_Data_M(write_Data_M), .PC_target_mux_M(PC_target_mux_M), .rd_M(rd_M),
    .pc4_M(pc4_M), .mode_M(mode_M)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, well clear of it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush_E = 0; regWrite_E = 0; memWrite_E = 0; memRead_E = 0;
    resultScr_E = 0; alu_ctrl_E = ALU_ADD; alu_srcB_E = 0; muxjalr = 0;
    jump_E = 0; branch_E = 0; funct3 = 0; md_en_E = 0;
    pc_E = 0; pc4_E = 0; imm_extended_E = 0; RD1_E = 0; RD2_E = 0; ResultW = 0;
    ForwardAE = FWD_RD; ForwardBE = FWD_RD; rd_E = 0; mode_E = 0;
  endtask

  // Issue one md op, count stall cycles (bounded), then check the M result.
  // With toggle_w set, ResultW is inverted after every stalled edge.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stalls,
                        input logic [31:0] exp_res, input bit toggle_w);
    int n;
    md_en_E = 1; funct3 = op; RD1_E = a; RD2_E = b; regWrite_E = 1;
    #1;
    n = 0;
    while (stall_E === 1'b1 && n < 200) begin
      n++;
      tick();
      if (toggle_w) ResultW = ~ResultW;
    end
    check({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
    tick();
    check({tag, "_res"}, ALURuslt_M, exp_res);
    check({tag, "_wr"}, {31'd0, regWrite_M}, 32'd1);
    md_en_E = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    #2;
    check("rst_stall", {31'd0, stall_E}, 32'd0);
    check("rst_regwrite", {31'd0, regWrite_M}, 32'd0);
    check("rst_alu_m", ALURuslt_M, 32'd0);
    check("rst_wdata", write_Data_M, 32'd0);
    tick();
    rst_n = 1;
    tick();

    // Forwarding from M and W into srcA, and forwarded rs2 into write data
    regWrite_E = 1; alu_srcB_E = 1; imm_extended_E = 1; RD1_E = 8;
    tick();
    check("add_seed", ALURuslt_M, 32'd9);
    RD1_E = 5; ForwardAE = FWD_M;
    tick();
    check("fwd_m", ALURuslt_M, 32'd10);
    ForwardAE = FWD_W; ResultW = 3; ForwardBE = FWD_W; RD2_E = 77;
    rd_E = 17; pc4_E = 32'h104; mode_E = 2; resultScr_E = 4; memWrite_E = 1; memRead_E = 1;
    tick();
    check("fwd_w", ALURuslt_M, 32'd4);
    check("wdata_fwd", write_Data_M, 32'd3);
    check("rd_m", {27'd0, rd_M}, 32'd17);
    check("pc4_m", pc4_M, 32'h104);
    check("mode_m", {29'd0, mode_M}, 32'd2);
    check("rscr_m", {29'd0, resultScr_M}, 32'd4);
    check("memwr_m", {31'd0, memWrite_M}, 32'd1);
    clear_inputs();

    // Signed compare
    regWrite_E = 1; alu_ctrl_E = ALU_SLT; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    tick();
    check("slt", ALURuslt_M, 32'd1);
    clear_inputs();

    // Branch and jump decisions and targets
    alu_ctrl_E = ALU_SUB; RD1_E = 42; RD2_E = 42; branch_E = 1;
    imm_extended_E = 8; pc_E = 32'h100; muxjalr = 1;
    #1;
    check("beq_taken", {31'd0, PCSrc_E}, 32'd1);
    check("beq_target", PC_target_E, 32'h108);
    RD2_E = 41;
    #1;
    check("beq_not_taken", {31'd0, PCSrc_E}, 32'd0);
    branch_E = 0; jump_E = 1; muxjalr = 0; RD1_E = 32'h200; imm_extended_E = 4;
    #1;
    check("jalr_taken", {31'd0, PCSrc_E}, 32'd1);
    check("jalr_target", PC_target_E, 32'h204);
    clear_inputs();
    tick();

    // RV32M: results, stall counts, special cases, back-to-back issue
    run_md("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB, 0);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 0);
    run_md("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 0);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 0);
    run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 0);
    run_md("divu", MD_DIVU, 32'd100, 32'd7, 33, 32'd14, 0);
    // srcA is forwarded from ResultW (-7); RD1_E holds an unrelated value
    ForwardAE = FWD_W; ResultW = 32'hFFFF_FFF9;
    run_md("rem_tog", MD_REM, 32'd123, 32'd2, 33, 32'hFFFF_FFFF, 1);
    ForwardAE = FWD_RD;
    run_md("divu_z", MD_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 0);
    run_md("rem_z", MD_REM, 32'd5, 32'd0, 1, 32'd5, 0);
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
    run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 0);

    // Flush in BUSY cycle 10 of a divide
    md_en_E = 1; funct3 = MD_DIV; RD1_E = 100; RD2_E = 3; regWrite_E = 1;
    #1;
    check("flush_pre_stall", {31'd0, stall_E}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    flush_E = 1;
    #1;
    check("flush_stall", {31'd0, stall_E}, 32'd0);
    tick();
    check("flush_bubble", {31'd0, regWrite_M}, 32'd0);
    clear_inputs();
    regWrite_E = 1; alu_srcB_E = 1; RD1_E = 2; imm_extended_E = 3;
    #1;
    check("post_flush_stall", {31'd0, stall_E}, 32'd0);
    tick();
    check("post_flush_add", ALURuslt_M, 32'd5);
    check("post_flush_wr", {31'd0, regWrite_M}, 32'd1);
    clear_inputs();

    // Reset in the middle of a divide
    md_en_E = 1; funct3 = MD_DIV; RD1_E = 100; RD2_E = 3; regWrite_E = 1;
    pc4_E = 32'h44; rd_E = 9; imm_extended_E = 32'h10;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 0;
    #1;
    check("rst_mid_stall", {31'd0, stall_E}, 32'd0);
    check("rst_mid_wr", {31'd0, regWrite_M}, 32'd0);
    check("rst_mid_alu", ALURuslt_M, 32'd0);
    check("rst_mid_rd", {27'd0, rd_M}, 32'd0);
    check("rst_mid_pc4", pc4_M, 32'd0);
    check("rst_mid_imm", imm_extended_M, 32'd0);
    clear_inputs();
    tick();
    rst_n = 1;
    regWrite_E = 1; alu_srcB_E = 1; RD1_E = 20; imm_extended_E = 22;
    tick();
    check("post_rst_add", ALURuslt_M, 32'd42);
    check("post_rst_stall", {31'd0, stall_E}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
